smvm_stream_parser: RTL and testbench

Front-end parser between the PS receive AXI-Stream FIFO (`M_AXIS_Recive_*`) and the SMVM compute core. It accepts 32-bit frames from the ARM side, checks the header and bounds, and delivers one registered COO element (row, col, value) per handshake to the core. Malformed frames are aborted and drained so the stream stays aligned with the next frame.

---
 rtl/smvm_stream_parser_pkg.sv | 32 +++
 rtl/smvm_stream_parser_if.sv | 23 ++
 rtl/smvm_stream_parser_sat_cnt16.sv | 21 ++
 rtl/smvm_stream_parser.sv | 215 +++++++++++++++++++++
 tb/tb_smvm_stream_parser.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smvm_stream_parser_pkg.sv
// Shared definitions for the SMVM stream parser, compute core and result packer.
package smvm_pkg;

    localparam logic [15:0] MAGIC = 16'h5A5A;
    localparam int          IDX_W = 16;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_MAGIC    = 3'd1,
        ERR_TKEEP    = 3'd2,
        ERR_TRUNC    = 3'd3,
        ERR_OVERLONG = 3'd4,
        ERR_RANGE    = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_IDX,
        ST_VAL,
        ST_EMIT,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic [31:0]      val;
        logic             last;
    } elem_t;

endpackage

// File: rtl/smvm_stream_parser_if.sv
// AXI-Stream input bus and COO element output bus of the stream parser.
interface smvm_axis_if;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;

    modport master (output s_tdata, s_tkeep, s_tlast, s_tvalid, input s_tready);
    modport slave  (input s_tdata, s_tkeep, s_tlast, s_tvalid, output s_tready);
endinterface

interface smvm_elem_if;
    logic        elem_valid;
    logic        elem_ready;
    logic [15:0] elem_row;
    logic [15:0] elem_col;
    logic [31:0] elem_val;
    logic        elem_last;

    modport master (output elem_valid, elem_row, elem_col, elem_val, elem_last, input elem_ready);
    modport slave  (input elem_valid, elem_row, elem_col, elem_val, elem_last, output elem_ready);
endinterface

// File: rtl/smvm_stream_parser_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/smvm_stream_parser.sv
// Parses header-checked COO frames from the PS receive FIFO into one registered
// element per handshake; malformed frames are aborted and drained to the next tlast.
module smvm_stream_parser
    import smvm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    smvm_axis_if.slave  axis,
    smvm_elem_if.master elem,
    output logic        hdr_valid,
    output logic [15:0] hdr_rows,
    output logic [15:0] hdr_cols,
    output logic [15:0] hdr_nnz,
    output logic        frame_abort,
    output logic [2:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    state_e      r_state, w_next_state;
    logic [15:0] r_nnz, r_row, r_col, r_cnt;
    logic [15:0] r_hdr_rows, r_hdr_cols, r_hdr_nnz;
    elem_t       r_elem;
    logic        r_elem_valid, r_drain_pend, r_hdr_valid, r_abort;
    err_e        r_err_code, w_err_val;

    logic w_tready, w_beat, w_keep_bad, w_final, w_fail;
    logic w_err_set, w_abort, w_nnz_load, w_hdr_load, w_hdr_accept, w_idx_load;
    logic w_elem_load, w_elem_last, w_drain_set, w_emit_done, w_frame_done;

    // Ready depends only on state (and reset), never on the core's elem_ready.
    assign w_tready   = rst_n && (r_state != ST_EMIT);
    assign w_beat     = axis.s_tvalid && w_tready;
    assign w_keep_bad = (axis.s_tkeep != 4'hF);
    assign w_final    = (({1'b0, r_cnt} + 17'd1) == {1'b0, r_nnz});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HDR0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        w_err_val    = ERR_NONE;
        w_fail       = 1'b0;
        w_abort      = 1'b0;
        w_nnz_load   = 1'b0;
        w_hdr_load   = 1'b0;
        w_hdr_accept = 1'b0;
        w_idx_load   = 1'b0;
        w_elem_load  = 1'b0;
        w_elem_last  = 1'b0;
        w_drain_set  = 1'b0;
        w_emit_done  = 1'b0;
        w_frame_done = 1'b0;

        unique case (r_state)
            ST_HDR0: if (w_beat) begin
                if (w_keep_bad) begin
                    w_fail = 1'b1; w_err_val = ERR_TKEEP;
                end else if (axis.s_tdata[31:16] != MAGIC) begin
                    w_fail = 1'b1; w_err_val = ERR_MAGIC;
                end else if (axis.s_tlast) begin
                    w_fail = 1'b1; w_err_val = ERR_TRUNC;
                end else begin
                    w_nnz_load   = 1'b1;
                    w_next_state = ST_HDR1;
                end
            end
            ST_HDR1: if (w_beat) begin
                if (w_keep_bad) begin
                    w_fail = 1'b1; w_err_val = ERR_TKEEP;
                end else begin
                    w_hdr_load = 1'b1;
                    if (axis.s_tdata[31:16] == '0 || axis.s_tdata[15:0] == '0) begin
                        w_fail = 1'b1; w_err_val = ERR_RANGE;
                    end else if (r_nnz == '0) begin
                        if (axis.s_tlast) begin
                            w_hdr_accept = 1'b1;
                            w_frame_done = 1'b1;
                            w_next_state = ST_HDR0;
                        end else begin
                            w_fail = 1'b1; w_err_val = ERR_OVERLONG;
                        end
                    end else if (axis.s_tlast) begin
                        w_fail = 1'b1; w_err_val = ERR_TRUNC;
                    end else begin
                        w_hdr_accept = 1'b1;
                        w_next_state = ST_IDX;
                    end
                end
            end
            ST_IDX: if (w_beat) begin
                if (w_keep_bad) begin
                    w_fail = 1'b1; w_err_val = ERR_TKEEP;
                end else if (axis.s_tlast) begin
                    w_fail = 1'b1; w_err_val = ERR_TRUNC;
                end else if (axis.s_tdata[31:16] >= r_hdr_rows || axis.s_tdata[15:0] >= r_hdr_cols) begin
                    w_fail = 1'b1; w_err_val = ERR_RANGE;
                end else begin
                    w_idx_load   = 1'b1;
                    w_next_state = ST_VAL;
                end
            end
            // An overlong final value is still delivered, then the tail is drained.
            ST_VAL: if (w_beat) begin
                if (w_keep_bad) begin
                    w_fail = 1'b1; w_err_val = ERR_TKEEP;
                end else if (w_final) begin
                    w_elem_load  = 1'b1;
                    w_elem_last  = axis.s_tlast;
                    w_next_state = ST_EMIT;
                    if (!axis.s_tlast) begin
                        w_err_set   = 1'b1;
                        w_err_val   = ERR_OVERLONG;
                        w_drain_set = 1'b1;
                    end
                end else if (axis.s_tlast) begin
                    w_fail = 1'b1; w_err_val = ERR_TRUNC;
                end else begin
                    w_elem_load  = 1'b1;
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: if (elem.elem_ready) begin
                w_emit_done = 1'b1;
                if (r_drain_pend) begin
                    w_next_state = ST_DRAIN;
                end else if (r_elem.last) begin
                    w_frame_done = 1'b1;
                    w_next_state = ST_HDR0;
                end else begin
                    w_next_state = ST_IDX;
                end
            end
            ST_DRAIN: if (w_beat && axis.s_tlast) begin
                w_abort      = 1'b1;
                w_next_state = ST_HDR0;
            end
            default: w_next_state = ST_HDR0;
        endcase

        if (w_fail) begin
            w_err_set = 1'b1;
            if (axis.s_tlast) begin
                w_abort      = 1'b1;
                w_next_state = ST_HDR0;
            end else begin
                w_next_state = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nnz        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_cnt        <= '0;
            r_hdr_rows   <= '0;
            r_hdr_cols   <= '0;
            r_hdr_nnz    <= '0;
            r_elem       <= '0;
            r_elem_valid <= 1'b0;
            r_drain_pend <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_abort      <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_hdr_valid <= w_hdr_accept;
            r_abort     <= w_abort;
            if (w_err_set) r_err_code <= w_err_val;
            if (w_nnz_load) r_nnz <= axis.s_tdata[15:0];
            if (w_hdr_load) begin
                r_hdr_rows <= axis.s_tdata[31:16];
                r_hdr_cols <= axis.s_tdata[15:0];
                r_hdr_nnz  <= r_nnz;
                r_cnt      <= '0;
            end
            if (w_idx_load) begin
                r_row <= axis.s_tdata[31:16];
                r_col <= axis.s_tdata[15:0];
            end
            if (w_elem_load) begin
                r_elem       <= '{row: r_row, col: r_col, val: axis.s_tdata, last: w_elem_last};
                r_elem_valid <= 1'b1;
                r_cnt        <= r_cnt + 16'd1;
                r_drain_pend <= w_drain_set;
            end else if (w_emit_done) begin
                r_elem_valid <= 1'b0;
            end
        end
    end

    sat_cnt16 u_frame_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_frame_done), .o_count(frame_cnt));
    sat_cnt16 u_err_cnt   (.clk(clk), .rst_n(rst_n), .i_inc(w_abort),      .o_count(err_cnt));

    assign axis.s_tready   = w_tready;
    assign elem.elem_valid = r_elem_valid;
    assign elem.elem_row   = r_elem.row;
    assign elem.elem_col   = r_elem.col;
    assign elem.elem_val   = r_elem.val;
    assign elem.elem_last  = r_elem.last;
    assign hdr_valid       = r_hdr_valid;
    assign hdr_rows        = r_hdr_rows;
    assign hdr_cols        = r_hdr_cols;
    assign hdr_nnz         = r_hdr_nnz;
    assign frame_abort     = r_abort;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_smvm_stream_parser.sv
// Scoreboard bench for smvm_stream_parser: directed frames, a monitor pops expected elements.
module tb_smvm_stream_parser;
    import smvm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    smvm_axis_if axis ();
    smvm_elem_if elem ();

    logic        hdrValid, frameAbort;
    logic [15:0] hdrRows, hdrCols, hdrNnz, frameCnt, errCnt;
    logic [2:0]  errCode;

    smvm_stream_parser dut (
        .clk(clk), .rst_n(rst_n), .axis(axis), .elem(elem),
        .hdr_valid(hdrValid), .hdr_rows(hdrRows), .hdr_cols(hdrCols), .hdr_nnz(hdrNnz),
        .frame_abort(frameAbort), .err_code(errCode), .frame_cnt(frameCnt), .err_cnt(errCnt)
    );

    int    total = 0, bad = 0;
    elem_t expQ[$];
    int    hdrSeen = 0, abortSeen = 0, expHdr = 0, expAbort = 0, expFrames = 0, expErrs = 0;
    int    readyMode = 0;
    logic  prevStall = 1'b0;
    elem_t held, cur;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic elem_t mkElem(input logic [15:0] r, input logic [15:0] c, input logic [31:0] v, input logic l);
        return '{row: r, col: c, val: v, last: l};
    endfunction

    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [3:0] keep);
        int  n = 0;
        bit  done = 0;
        axis.s_tdata  = data;
        axis.s_tlast  = last;
        axis.s_tkeep  = keep;
        axis.s_tvalid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (axis.s_tready) done = 1;
            n++;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL beat_timeout: got s_tready=0 expected s_tready=1 (beat %h)", data);
        end
    endtask

    task automatic endStream();
        axis.s_tvalid = 1'b0;
        axis.s_tlast  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL elem_timeout: got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input logic [2:0] expErr);
        checkOutput("err_code",    errCode,   expErr);
        checkOutput("frame_cnt",   frameCnt,  expFrames);
        checkOutput("err_cnt",     errCnt,    expErrs);
        checkOutput("hdr_pulses",  hdrSeen,   expHdr);
        checkOutput("abort_count", abortSeen, expAbort);
    endtask

    task automatic goodFrame();
        expQ.push_back(mkElem(16'd0, 16'd1, 32'h10, 1'b0));
        expQ.push_back(mkElem(16'd2, 16'd3, 32'h20, 1'b0));
        expQ.push_back(mkElem(16'd3, 16'd0, 32'h30, 1'b1));
        applyStimulus(32'h5A5A0003, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00000001, 1'b0, 4'hF);
        applyStimulus(32'h00000010, 1'b0, 4'hF);
        applyStimulus(32'h00020003, 1'b0, 4'hF);
        applyStimulus(32'h00000020, 1'b0, 4'hF);
        applyStimulus(32'h00030000, 1'b0, 4'hF);
        applyStimulus(32'h00000030, 1'b1, 4'hF);
        checkOutput("val_latency", elem.elem_valid, 1'b1);
        endStream();
        expHdr++;
        expFrames++;
        waitIdle();
    endtask

    // elem_ready driver: always ready, random, or held low
    initial begin
        elem.elem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       elem.elem_ready = 1'b1;
                1:       elem.elem_ready = 1'($urandom_range(0, 1));
                default: elem.elem_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops on handshake, plus stall-stability and ready checks
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                cur = mkElem(elem.elem_row, elem.elem_col, elem.elem_val, elem.elem_last);
                if (prevStall) begin
                    checkOutput("stall_valid", elem.elem_valid, 1'b1);
                    checkOutput("stall_stable", cur, held);
                end
                if (elem.elem_valid) begin
                    checkOutput("tready_in_emit", axis.s_tready, 1'b0);
                    if (elem.elem_ready) begin
                        prevStall = 1'b0;
                        if (expQ.size() == 0) begin
                            total++; bad++;
                            $display("[TB] FAIL unexpected_elem: got %0h expected none", cur);
                        end else begin
                            checkOutput("elem", cur, expQ.pop_front());
                        end
                    end else begin
                        prevStall = 1'b1;
                        held = cur;
                    end
                end else begin
                    prevStall = 1'b0;
                end
                if (hdrValid)   hdrSeen++;
                if (frameAbort) abortSeen++;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        axis.s_tdata  = '0;
        axis.s_tkeep  = 4'hF;
        axis.s_tlast  = 1'b0;
        axis.s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tready",    axis.s_tready,   1'b0);
        checkOutput("rst_elem_vld",  elem.elem_valid, 1'b0);
        checkOutput("rst_hdr_valid", hdrValid,        1'b0);
        checkOutput("rst_abort",     frameAbort,      1'b0);
        checkCounters(3'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_tready", axis.s_tready, 1'b1);

        $display("[TB] good frame");
        goodFrame();
        checkCounters(ERR_NONE);
        checkOutput("hdr_rows", hdrRows, 16'd4);
        checkOutput("hdr_cols", hdrCols, 16'd4);
        checkOutput("hdr_nnz",  hdrNnz,  16'd3);

        $display("[TB] backpressure");
        readyMode = 1;
        goodFrame();
        readyMode = 0;
        checkCounters(ERR_NONE);

        $display("[TB] bad magic");
        applyStimulus(32'h12340002, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00010001, 1'b0, 4'hF);
        applyStimulus(32'h00000011, 1'b0, 4'hF);
        applyStimulus(32'h00020002, 1'b0, 4'hF);
        applyStimulus(32'h00000022, 1'b1, 4'hF);
        endStream();
        expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_MAGIC);
        goodFrame();
        checkCounters(ERR_MAGIC);

        $display("[TB] truncation");
        applyStimulus(32'h5A5A0002, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00010002, 1'b0, 4'hF);
        applyStimulus(32'h00000005, 1'b1, 4'hF);
        endStream();
        expHdr++; expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_TRUNC);

        $display("[TB] overlong");
        expQ.push_back(mkElem(16'd1, 16'd1, 32'h77, 1'b0));
        applyStimulus(32'h5A5A0001, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00010001, 1'b0, 4'hF);
        applyStimulus(32'h00000077, 1'b0, 4'hF);
        applyStimulus(32'hDEAD0001, 1'b0, 4'hF);
        applyStimulus(32'hDEAD0002, 1'b1, 4'hF);
        endStream();
        expHdr++; expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_OVERLONG);

        $display("[TB] range");
        applyStimulus(32'h5A5A0001, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00050000, 1'b0, 4'hF);
        applyStimulus(32'h00000001, 1'b1, 4'hF);
        endStream();
        expHdr++; expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_RANGE);

        $display("[TB] tkeep");
        applyStimulus(32'h5A5A0001, 1'b0, 4'h7);
        applyStimulus(32'h00040004, 1'b1, 4'hF);
        endStream();
        expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_TKEEP);

        $display("[TB] empty frame");
        applyStimulus(32'h5A5A0000, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b1, 4'hF);
        endStream();
        expHdr++; expFrames++;
        waitIdle();
        checkCounters(ERR_TKEEP);

        $display("[TB] reset mid-frame");
        readyMode = 2;
        @(posedge clk);
        #2;
        applyStimulus(32'h5A5A0002, 1'b0, 4'hF);
        applyStimulus(32'h00040004, 1'b0, 4'hF);
        applyStimulus(32'h00000000, 1'b0, 4'hF);
        applyStimulus(32'h000000AA, 1'b0, 4'hF);
        endStream();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stuck_valid",  elem.elem_valid, 1'b1);
        checkOutput("stuck_val",    elem.elem_val,   32'hAA);
        checkOutput("stuck_tready", axis.s_tready,   1'b0);
        rst_n = 1'b0;
        #2;
        hdrSeen = 0; abortSeen = 0; expHdr = 0; expAbort = 0; expFrames = 0; expErrs = 0;
        checkOutput("mid_rst_tready",   axis.s_tready,   1'b0);
        checkOutput("mid_rst_elem_vld", elem.elem_valid, 1'b0);
        checkOutput("mid_rst_elem_val", elem.elem_val,   32'h0);
        checkOutput("mid_rst_hdr_rows", hdrRows,         16'h0);
        checkCounters(3'd0);
        repeat (2) @(posedge clk);
        #1;
        readyMode = 0;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_post_tready", axis.s_tready, 1'b1);
        applyStimulus(32'h00010001, 1'b0, 4'hF);
        applyStimulus(32'h000000BB, 1'b1, 4'hF);
        endStream();
        expAbort++; expErrs++;
        waitIdle();
        checkCounters(ERR_MAGIC);
        goodFrame();
        checkCounters(ERR_MAGIC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
